// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader_if
// Description : Valid/ready output stream of the register-file dump reader.
//               Each beat carries one register value and its address.
//   master : out_data, out_addr, out_valid driven; out_ready sampled
//   slave  : out_data, out_addr, out_valid sampled; out_ready driven
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dump_reader_if #(
  parameter int AW = 5,
  parameter int DW = 64
);
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data,
    output out_addr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_addr,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Read-side initiator for the 32x64 register file. On start it
//               walks [first_addr, last_addr] through one combinational read
//               port and streams (address, value) pairs over a valid/ready
//               interface, then pulses done for one cycle.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active low
//               start      - begin a dump (ignored while busy)
//               first_addr - first register of range, latched on start
//               last_addr  - last register of range (inclusive)
//               ra / rd    - regfile read address / combinational read data
//               out        - stream master (out_data/out_addr/out_valid/out_ready)
//               busy       - dump in progress
//               done       - one-cycle pulse after the final handshake
// Options     : DUMP_SKIP_ZERO_EN - when defined, registers reading zero are
//               skipped rather than emitted.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
  parameter int AW = 5,
  parameter int DW = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         first_addr,
  input  logic [AW-1:0]         last_addr,
  output logic [AW-1:0]         ra,
  input  logic [DW-1:0]         rd,
  regfile_dump_reader_if.master out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic [AW-1:0] r_cur, w_cur;
  logic [AW-1:0] r_last, w_last;
  logic [AW-1:0] r_addr, w_addr;
  logic [DW-1:0] r_data, w_data;
  logic          r_valid, w_valid;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          w_load;
  logic          w_skip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_last  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cur   <= w_cur;
      r_last  <= w_last;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cur   = r_cur;
    w_last  = r_last;
    w_addr  = r_addr;
    w_data  = r_data;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_done  = 1'b0;
    // Output register may take a new word when empty or being drained now.
    w_load  = !r_valid || out.out_ready;
`ifdef DUMP_SKIP_ZERO_EN
    w_skip  = (rd == '0);
`else
    w_skip  = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (first_addr <= last_addr) begin
            w_cur   = first_addr;
            w_last  = last_addr;
            w_busy  = 1'b1;
            w_state = S_STREAM;
          end else begin
            // Empty range: report completion without ever becoming busy.
            w_done = 1'b1;
          end
        end
      end

      S_STREAM: begin
        if (w_skip) begin
          // A skipped address never needs the output slot, so the walk keeps
          // going even under backpressure; a held word may still drain.
          if (r_valid && out.out_ready) begin
            w_valid = 1'b0;
          end
          if (r_cur == r_last) begin
            w_state = S_DRAIN;
          end else begin
            w_cur = r_cur + AW'(1);
          end
        end else if (w_load) begin
          w_data  = rd;
          w_addr  = r_cur;
          w_valid = 1'b1;
          // cur parks on last so ra keeps pointing at it during DRAIN.
          if (r_cur == r_last) begin
            w_state = S_DRAIN;
          end else begin
            w_cur = r_cur + AW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (w_load) begin
          w_valid = 1'b0;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign ra            = r_cur;
  assign out.out_data  = r_data;
  assign out.out_addr  = r_addr;
  assign out.out_valid = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Directed self-checking bench for regfile_dump_reader. A
//               regfile model feeds rd; a scoreboard predicts the word stream,
//               busy and done from the dump rules, and directed tests pin key
//               values with literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;
  localparam int AW = 5;
  localparam int DW = 64;
`ifdef DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          busy;
  logic          done;
  logic [DW-1:0] rf [32];

  int n_total = 0;
  int n_pass  = 0;

  regfile_dump_reader_if #(.AW(AW), .DW(DW)) dif ();

  regfile_dump_reader #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .ra         (ra),
    .rd         (rd),
    .out        (dif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
    return (a == 5'd31) ? '0 : rf[a];
  endfunction

  always_comb rd = rf_read(ra);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- scoreboard / model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  word_t         q[$];
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  bit            m_relaxed = 1'b0;  // trailing skipped zeros: done time not fixed
  bit            stalled = 1'b0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [AW-1:0] got_addr [64];
  logic [DW-1:0] got_data [64];
  int            got_cnt = 0;

  always @(negedge clk) begin
    bit    nd;
    bit    nb;
    word_t w;
    if (!rst) begin
      q.delete();
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_relaxed = 1'b0;
      stalled   = 1'b0;
    end else begin
      if (!m_relaxed) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
      end
      if (stalled) begin
        chk("hold_valid", 64'(dif.out_valid), 64'd1);
        chk("hold_addr", 64'(dif.out_addr), 64'(s_addr));
        chk("hold_data", dif.out_data, s_data);
      end
      nd = 1'b0;
      nb = m_busy;
      if (dif.out_valid && dif.out_ready) begin
        if (q.size() == 0) begin
          fail_now("extra_word");
        end else begin
          w = q.pop_front();
          chk("word_addr", 64'(dif.out_addr), 64'(w.a));
          chk("word_data", dif.out_data, w.d);
          if (got_cnt < 64) begin
            got_addr[got_cnt] = dif.out_addr;
            got_data[got_cnt] = dif.out_data;
          end
          got_cnt++;
          if (q.size() == 0 && m_busy && !m_relaxed) begin
            nd = 1'b1;
            nb = 1'b0;
          end
        end
      end
      if (m_relaxed && done) begin
        chk("relaxed_leftover", 64'(q.size()), 64'd0);
        nb        = 1'b0;
        m_relaxed = 1'b0;
      end
      if (!m_busy && start) begin
        if (first_addr <= last_addr) begin
          nb = 1'b1;
          for (int a = int'(first_addr); a <= int'(last_addr); a++) begin
            w.a = AW'(a);
            w.d = rf_read(AW'(a));
            if (!(SKIP && w.d == '0)) q.push_back(w);
          end
          m_relaxed = SKIP && (rf_read(last_addr) == '0);
        end else begin
          nd = 1'b1;
        end
      end
      stalled = dif.out_valid && !dif.out_ready;
      s_addr  = dif.out_addr;
      s_data  = dif.out_data;
      m_done  = nd;
      m_busy  = nb;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    @(posedge clk); #1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = done;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      seen = done;
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic wait_word(input logic [AW-1:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = dif.out_valid && (dif.out_addr == a);
    end
    if (!seen) fail_now("word_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    dif.out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ra", 64'(ra), 64'd0);
    chk("rst_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_addr", 64'(dif.out_addr), 64'd0);
    chk("rst_data", dif.out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b1;

    // 1: basic dump 0..3, ready high
    rf[0] = 64'h11; rf[1] = 64'h22; rf[2] = 64'h33; rf[3] = 64'h44;
    base = got_cnt;
    start_dump(5'd0, 5'd3);
    chk("t1_valid_after_1", 64'(dif.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t1_valid_after_2", 64'(dif.out_valid), 64'd1);
    chk("t1_first_addr", 64'(dif.out_addr), 64'd0);
    chk("t1_first_data", dif.out_data, 64'h11);
    wait_done();
    chk("t1_busy_with_done", 64'(busy), 64'd0);
    chk("t1_count", 64'(got_cnt - base), 64'd4);
    chk("t1_last_addr", 64'(got_addr[base+3]), 64'd3);
    chk("t1_last_data", got_data[base+3], 64'h44);

    // 2: backpressure on word 1, plus a start while busy
    base = got_cnt;
    start_dump(5'd0, 5'd3);
    wait_word(5'd1);
    dif.out_ready = 1'b0;
    first_addr = 5'd10; last_addr = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t2_stall_addr", 64'(dif.out_addr), 64'd1);
    chk("t2_stall_data", dif.out_data, 64'h22);
    dif.out_ready = 1'b1;
    wait_done();
    chk("t2_count", 64'(got_cnt - base), 64'd4);
    chk("t2_resume_addr", 64'(got_addr[base+2]), 64'd2);

    // 3: top of the file, no wrap
    rf[29] = 64'hA; rf[30] = 64'hB;
    base = got_cnt;
    start_dump(5'd29, 5'd31);
    wait_done();
    chk("t3_w0_addr", 64'(got_addr[base]), 64'd29);
    chk("t3_w1_data", got_data[base+1], 64'hB);
`ifdef DUMP_SKIP_ZERO_EN
    chk("t3_count", 64'(got_cnt - base), 64'd2);
`else
    chk("t3_count", 64'(got_cnt - base), 64'd3);
    chk("t3_w2_addr", 64'(got_addr[base+2]), 64'd31);
    chk("t3_w2_data", got_data[base+2], 64'd0);
`endif

    // 4: empty range
    base = got_cnt;
    start_dump(5'd5, 5'd2);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_valid", 64'(dif.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t4_done_drop", 64'(done), 64'd0);
    chk("t4_count", 64'(got_cnt - base), 64'd0);

    // 5: reset mid-dump, then a one-word dump
    for (int i = 0; i < 8; i++) rf[i] = 64'h100 + 64'(i);
    start_dump(5'd0, 5'd7);
    wait_word(5'd2);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(dif.out_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_ra", 64'(ra), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    rf[0] = 64'h99;
    base = got_cnt;
    start_dump(5'd0, 5'd0);
    wait_done();
    chk("t5_count", 64'(got_cnt - base), 64'd1);
    chk("t5_data", got_data[base], 64'h99);

    // 6: zero-valued register in the middle
    rf[0] = 64'h5; rf[1] = 64'h0; rf[2] = 64'h7;
    base = got_cnt;
    start_dump(5'd0, 5'd2);
    wait_done();
`ifdef DUMP_SKIP_ZERO_EN
    chk("t6_count", 64'(got_cnt - base), 64'd2);
    chk("t6_w1_addr", 64'(got_addr[base+1]), 64'd2);
    chk("t6_w1_data", got_data[base+1], 64'h7);
`else
    chk("t6_count", 64'(got_cnt - base), 64'd3);
    chk("t6_w1_addr", 64'(got_addr[base+1]), 64'd1);
    chk("t6_w1_data", got_data[base+1], 64'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
